// File: rtl/boxcar_pkg.sv
// Shared types and constants for the boxcar moving-sum filter.
// Imported by boxcar_sum and boxcar_scale.
package boxcar_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int C_NBITS_ADDR = 8;
  localparam int C_NBITS_DATA = 14;

  function automatic int sum_width(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

  localparam int C_NBITS_SUM = sum_width(C_NBITS_DATA, C_NBITS_ADDR);

  localparam logic [C_NBITS_DATA-1:0] C_MEAN_MAX = '1;

endpackage

// File: rtl/boxcar_scale.sv
// Registered power-of-two scaling with saturation from sum to mean.
// Define BOXCAR_ROUND_EN for round-half-up instead of truncation.
module boxcar_scale
  import boxcar_pkg::*;
#(
  parameter int P_NBITS_DATA = C_NBITS_DATA,
  parameter int P_NBITS_SUM  = C_NBITS_SUM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_NBITS_SUM-1:0]  i_sum,
  input  logic [4:0]              i_shift,
  output logic [P_NBITS_DATA-1:0] o_mean
);

  localparam int LP_W = P_NBITS_SUM + 1;

  logic [LP_W-1:0]         w_ext;
  logic [LP_W-1:0]         w_shd;
  logic [P_NBITS_DATA-1:0] w_mean;
  logic [P_NBITS_DATA-1:0] r_mean;

`ifdef BOXCAR_ROUND_EN
  logic [LP_W-1:0] w_half;

  always_comb begin
    w_half = '0;
    if (i_shift != 5'd0)
      w_half = LP_W'(1) << (i_shift - 5'd1);
    w_ext = {1'b0, i_sum} + w_half;
  end
`else
  always_comb begin
    w_ext = {1'b0, i_sum};
  end
`endif

  always_comb begin
    w_shd  = w_ext >> i_shift;
    w_mean = w_shd[P_NBITS_DATA-1:0];
    if (int'(i_shift) >= P_NBITS_SUM)
      w_mean = '0;
    else if (|w_shd[LP_W-1:P_NBITS_DATA])
      w_mean = '1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_mean <= '0;
    else
      r_mean <= w_mean;
  end

  assign o_mean = r_mean;

endmodule

// File: rtl/boxcar_sum.sv
// Moving-sum (boxcar) filter fed by a RAM delay line.
// Optional BOXCAR_ROUND_EN selects rounding in the mean path.
module boxcar_sum
  import boxcar_pkg::*;
#(
  parameter int P_NBITS_ADDR = C_NBITS_ADDR,
  parameter int P_NBITS_DATA = C_NBITS_DATA,
  parameter int P_NBITS_SUM  = P_NBITS_DATA + P_NBITS_ADDR
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr,
  input  logic [P_NBITS_DATA-1:0] i_d,
  input  logic [P_NBITS_DATA-1:0] i_d_dly,
  input  logic                    i_dly_valid,
  input  logic [4:0]              i_avg_shift,
  output logic [P_NBITS_SUM-1:0]  o_sum,
  output logic [P_NBITS_DATA-1:0] o_mean,
  output logic                    o_sum_valid,
  output logic                    o_sum_err
);

  localparam int LP_PAD = P_NBITS_SUM - P_NBITS_DATA;

  state_t                  r_state, w_state_nxt;
  logic [P_NBITS_SUM-1:0]  r_sum, w_sum_nxt;
  logic [P_NBITS_ADDR-1:0] r_fill_cnt, w_fill_nxt;
  logic                    r_valid, w_valid_nxt;
  logic                    r_err, w_err_nxt;

  logic [P_NBITS_SUM-1:0]  w_add;
  logic [P_NBITS_SUM-1:0]  w_dly;
  logic [P_NBITS_SUM-1:0]  w_upd;
  logic                    w_under;

  assign w_add   = r_sum + {{LP_PAD{1'b0}}, i_d};
  assign w_dly   = {{LP_PAD{1'b0}}, i_d_dly};
  assign w_under = w_add < w_dly;
  // misaligned inputs clamp to zero rather than wrapping
  assign w_upd   = w_under ? '0 : w_add - w_dly;

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_fill_nxt  = r_fill_cnt;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    unique case (r_state)
      ST_FILL: begin
        w_valid_nxt = 1'b0;
        if (i_wr) begin
          if (r_fill_cnt != '1)
            w_fill_nxt = r_fill_cnt + 1'b1;
          if (i_dly_valid) begin
            w_sum_nxt   = w_upd;
            w_err_nxt   = r_err | w_under;
            w_state_nxt = ST_RUN;
          end else begin
            w_sum_nxt = w_add;
          end
        end
      end
      ST_RUN: begin
        if (!i_dly_valid) begin
          w_sum_nxt   = '0;
          w_fill_nxt  = '0;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_FILL;
        end else if (i_wr) begin
          w_sum_nxt   = w_upd;
          w_err_nxt   = r_err | w_under;
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FILL;
      r_sum      <= '0;
      r_fill_cnt <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sum      <= w_sum_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  boxcar_scale #(
    .P_NBITS_DATA(P_NBITS_DATA),
    .P_NBITS_SUM (P_NBITS_SUM)
  ) u_scale (
    .clk    (clk),
    .rst    (rst),
    .i_sum  (w_sum_nxt),
    .i_shift(i_avg_shift),
    .o_mean (o_mean)
  );

  assign o_sum       = r_sum;
  assign o_sum_valid = r_valid;
  assign o_sum_err   = r_err;

endmodule

// File: doc/boxcar_sum.md
Name: boxcar_sum

Overview:
- Moving-sum (boxcar) filter that sits directly downstream of the RAM delay line.
- Consumes the undelayed sample stream and the same stream delayed by N samples, plus the delay line's valid flag.
- Keeps a running sum over the last N written samples using sum <= sum + d - d_dly.
- Outputs the sum and a power-of-two scaled mean for trigger and baseline logic.

Parameters:
- P_NBITS_ADDR, 8: delay/window length width; window N ≤ 2^P_NBITS_ADDR-1.
- P_NBITS_DATA, 14: unsigned sample width.
- P_NBITS_SUM, P_NBITS_DATA+P_NBITS_ADDR: accumulator width; this width never overflows for a legal N.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr  in  1  sample strobe, aligned with d and d_dly.
- d  in  P_NBITS_DATA  newest sample (unsigned).
- d_dly  in  P_NBITS_DATA  sample written N strobes earlier, from the delay line.
- dly_valid  in  1  delay line primed; d_dly is meaningful while high.
- avg_shift  in  5  mean = sum >> avg_shift; static during RUN.
- sum  out  P_NBITS_SUM  running window sum, registered.
- mean  out  P_NBITS_DATA  scaled sum, saturated to P_NBITS_DATA bits, registered.
- sum_valid  out  1  sum spans a full window.
- sum_err  out  1  sticky: accumulator underflow detected (misaligned inputs).

Behaviour:
Reset and outputs:
- rst is synchronous and has priority over everything else.
- Reset values: sum=0, mean=0, sum_valid=0, sum_err=0, state=FILL, fill_cnt=0.

State machine (2 states):
- FILL
  - On wr: sum <= sum + d; fill_cnt++ (saturating at all-ones).
  - On wr with dly_valid=1: sum <= sum + d - d_dly instead, and go to RUN.
  - sum_valid=0 throughout.
- RUN
  - On wr: sum <= sum + d - d_dly.
  - sum_valid=1 from the first RUN-state update onward.
  - dly_valid falling (delay line re-priming, e.g. window length change) clears sum and fill_cnt, drops sum_valid the next cycle, and returns to FILL. This takes priority over a simultaneous wr; that sample is discarded.
- No wr: all state holds. Gaps in wr are allowed in both states.

Timing and arithmetic:
- Latency: sum, mean and sum_valid update on the clock edge after the wr cycle, i.e. 1 cycle.
- Arithmetic is unsigned at P_NBITS_SUM bits, with operands zero-extended.
- Underflow check: if (sum + d) < d_dly in RUN, sum_err <= 1 (sticky until rst) and sum <= 0. Never wrap.
- mean = sum >> avg_shift.
  - avg_shift ≥ P_NBITS_SUM gives 0.
  - If the shifted result exceeds 2^P_NBITS_DATA-1, mean is all-ones.
- mean is computed from the next-state sum, so it has the same 1-cycle latency as sum.

Optional Feature:
BOXCAR_ROUND_EN
- Defined: mean = (sum + (1 << (avg_shift-1))) >> avg_shift, i.e. round-half-up.
  - avg_shift=0 bypasses the rounding term.
  - The addition uses P_NBITS_SUM+1 bits, then saturates as above.
- Undefined: truncating shift only, with no extra adder.

Decomposition:
- Shared package boxcar_pkg:
  - state enum (FILL, RUN).
  - Width helper constant for P_NBITS_SUM.
  - Saturation max constant.
- One natural sub-module: boxcar_scale.
  - Registered shift, optional rounding and saturation from sum to mean.
  - Holds the BOXCAR_ROUND_EN logic.
- The accumulator and FSM stay in the top.

Test Plan:
1. Fill/run: N=4 via dly_valid rising after 4 wr, d=10 constant, d_dly=0 until primed then 10 -> sum 10,20,30,40 in FILL, then holds 40 with sum_valid=1 from the first RUN update; mean=10 with avg_shift=2.
2. Step: N=4 in RUN with sum=40 (all 10), then d=20 -> sum 50,60,70,80 over 4 wr, then flat at 80; mean steps 12,15,17,20 truncated (13,15,18,20 with BOXCAR_ROUND_EN).
3. wr gaps: wr at 25% duty with the same data as scenario 1 -> identical sum sequence; outputs hold between strobes.
4. Re-prime: in RUN, drop dly_valid for one cycle with a simultaneous wr -> sum=0, sum_valid=0 the next cycle, FSM in FILL; refill gives the correct window sum.
5. Underflow: in RUN with sum=5, present d=0, d_dly=9 -> sum_err=1, sum=0; sum_err stays 1 through further traffic until rst.
6. Reset mid-RUN plus saturation:
   - rst during wr -> all outputs 0 next cycle.
   - Then avg_shift=0 with sum=2^P_NBITS_DATA+3 -> mean=all-ones.
